// File: rtl/lsq_issue_queue.sv
// In-order load/store issue queue: holds memory ops until address (and store data) are ready.
// Optional macro LSQ_ADDR_BYPASS_EN lets the head issue with the AGU address broadcast this cycle.
module lsq_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 5,
    parameter int P_W    = 5,
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_freeze_back,
    input  logic              i_full_FIFO,
    input  logic              i_alloc_valid,
    input  logic              i_alloc_mode,
    input  logic [P_W-1:0]    i_alloc_Px,
    input  logic              i_alloc_Px_ready,
    input  logic [TAG_W-1:0]  i_alloc_tag_ROB,
    output logic              o_full_LSQ,
    input  logic              i_valid_Addr_agu,
    input  logic [TAG_W-1:0]  i_tag_ROB_Result_agu,
    input  logic [ADDR_W-1:0] i_Addr_agu,
    input  logic              i_valid_Result_add,
    input  logic              i_valid_Result_mul,
    input  logic              i_valid_Result_ls,
    input  logic [P_W-1:0]    i_Pw_Result_add,
    input  logic [P_W-1:0]    i_Pw_Result_mul,
    input  logic [P_W-1:0]    i_Pw_Result_ls,
    input  logic              i_mode_ls,
    output logic              o_valid_ls,
    output logic              o_mode,
    output logic [P_W-1:0]    o_Px,
    output logic [ADDR_W-1:0] o_Addr,
    output logic [TAG_W-1:0]  o_tag_ROB_ls
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic              r_v     [DEPTH];
    logic              r_mode  [DEPTH];
    logic [P_W-1:0]    r_px    [DEPTH];
    logic              r_rdy_x [DEPTH];
    logic [TAG_W-1:0]  r_tag   [DEPTH];
    logic [ADDR_W-1:0] r_addr  [DEPTH];
    logic              r_rdy_a [DEPTH];

    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [PW:0]       r_count;
    logic              r_full;

    logic              r_valid_ls;
    logic              r_mode_o;
    logic [P_W-1:0]    r_px_o;
    logic [ADDR_W-1:0] r_addr_o;
    logic [TAG_W-1:0]  r_tag_o;

    logic              w_alloc;
    logic              w_issue;
    logic              w_head_addr_ok;
    logic              w_head_ready;
    logic [ADDR_W-1:0] w_head_addr;
    logic              w_agu_head_hit;
    logic              w_alloc_agu_hit;
    logic [PW:0]       w_cnt_next;

    // Load results only wake stores when the ls broadcast is itself a load.
    function automatic logic wake_hit(input logic [P_W-1:0] p);
        return (i_valid_Result_add && (i_Pw_Result_add == p)) ||
               (i_valid_Result_mul && (i_Pw_Result_mul == p)) ||
               (i_valid_Result_ls && !i_mode_ls && (i_Pw_Result_ls == p));
    endfunction

    always_comb begin
        w_agu_head_hit  = i_valid_Addr_agu && (r_tag[r_head] == i_tag_ROB_Result_agu);
        w_alloc_agu_hit = i_valid_Addr_agu && (i_alloc_tag_ROB == i_tag_ROB_Result_agu);
`ifdef LSQ_ADDR_BYPASS_EN
        w_head_addr_ok  = r_rdy_a[r_head] | w_agu_head_hit;
        w_head_addr     = r_rdy_a[r_head] ? r_addr[r_head] : i_Addr_agu;
`else
        w_head_addr_ok  = r_rdy_a[r_head];
        w_head_addr     = r_addr[r_head];
`endif
        w_head_ready = r_v[r_head] & w_head_addr_ok & r_rdy_x[r_head]
                     & !(r_mode[r_head] & i_full_FIFO);
        w_issue      = !i_freeze_back & w_head_ready;
        w_alloc      = i_alloc_valid & !r_full;
        w_cnt_next   = r_count;
        if (w_alloc) w_cnt_next = w_cnt_next + CNT_ONE;
        if (w_issue) w_cnt_next = w_cnt_next - CNT_ONE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_v[i]     <= 1'b0;
                r_mode[i]  <= 1'b0;
                r_px[i]    <= '0;
                r_rdy_x[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_addr[i]  <= '0;
                r_rdy_a[i] <= 1'b0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_v[i]     <= 1'b0;
                r_rdy_x[i] <= 1'b0;
                r_rdy_a[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_v[i]) begin
                    if (!r_rdy_a[i] && i_valid_Addr_agu && (r_tag[i] == i_tag_ROB_Result_agu)) begin
                        r_addr[i]  <= i_Addr_agu;
                        r_rdy_a[i] <= 1'b1;
                    end
                    if (r_mode[i] && wake_hit(r_px[i]))
                        r_rdy_x[i] <= 1'b1;
                end
            end
            if (w_issue)
                r_v[r_head] <= 1'b0;
            // Tail slot is never valid when allocating, so the loop above cannot touch it.
            if (w_alloc) begin
                r_v[r_tail]     <= 1'b1;
                r_mode[r_tail]  <= i_alloc_mode;
                r_px[r_tail]    <= i_alloc_Px;
                r_rdy_x[r_tail] <= !i_alloc_mode | i_alloc_Px_ready | wake_hit(i_alloc_Px);
                r_tag[r_tail]   <= i_alloc_tag_ROB;
                r_addr[r_tail]  <= w_alloc_agu_hit ? i_Addr_agu : '0;
                r_rdy_a[r_tail] <= w_alloc_agu_hit;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_issue) r_head <= r_head + PTR_ONE;
            if (w_alloc) r_tail <= r_tail + PTR_ONE;
            r_count <= w_cnt_next;
            r_full  <= (w_cnt_next == CNT_FULL);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid_ls <= 1'b0;
            r_mode_o   <= 1'b0;
            r_px_o     <= '0;
            r_addr_o   <= '0;
            r_tag_o    <= '0;
        end else if (i_flush) begin
            r_valid_ls <= 1'b0;
            r_mode_o   <= 1'b0;
            r_px_o     <= '0;
            r_addr_o   <= '0;
            r_tag_o    <= '0;
        end else if (!i_freeze_back) begin
            r_valid_ls <= w_head_ready;
            if (w_head_ready) begin
                r_mode_o <= r_mode[r_head];
                r_px_o   <= r_px[r_head];
                r_addr_o <= w_head_addr;
                r_tag_o  <= r_tag[r_head];
            end
        end
    end

    assign o_full_LSQ   = r_full;
    assign o_valid_ls   = r_valid_ls;
    assign o_mode       = r_mode_o;
    assign o_Px         = r_px_o;
    assign o_Addr       = r_addr_o;
    assign o_tag_ROB_ls = r_tag_o;

endmodule

// File: tb/tb_lsq_issue_queue.sv
// Self-checking bench for lsq_issue_queue: directed scenarios plus random traffic against a queue model.
module tb_lsq_issue_queue;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 5;
    localparam int P_W    = 5;
    localparam int ADDR_W = 16;

    logic clk, rst_n;
    logic flush, freeze, full_fifo;
    logic alloc_valid, alloc_mode, alloc_rdy;
    logic [P_W-1:0] alloc_px;
    logic [TAG_W-1:0] alloc_tag;
    logic full_lsq;
    logic agu_v;
    logic [TAG_W-1:0] agu_tag;
    logic [ADDR_W-1:0] agu_addr;
    logic va, vm, vl, mode_ls;
    logic [P_W-1:0] pa, pm, pl;
    logic valid_ls, mode_o;
    logic [P_W-1:0] px_o;
    logic [ADDR_W-1:0] addr_o;
    logic [TAG_W-1:0] tag_o;

    lsq_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .P_W(P_W), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_freeze_back(freeze),
        .i_full_FIFO(full_fifo), .i_alloc_valid(alloc_valid), .i_alloc_mode(alloc_mode),
        .i_alloc_Px(alloc_px), .i_alloc_Px_ready(alloc_rdy), .i_alloc_tag_ROB(alloc_tag),
        .o_full_LSQ(full_lsq), .i_valid_Addr_agu(agu_v), .i_tag_ROB_Result_agu(agu_tag),
        .i_Addr_agu(agu_addr), .i_valid_Result_add(va), .i_valid_Result_mul(vm),
        .i_valid_Result_ls(vl), .i_Pw_Result_add(pa), .i_Pw_Result_mul(pm),
        .i_Pw_Result_ls(pl), .i_mode_ls(mode_ls), .o_valid_ls(valid_ls), .o_mode(mode_o),
        .o_Px(px_o), .o_Addr(addr_o), .o_tag_ROB_ls(tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              mode;
        logic [P_W-1:0]    px;
        logic              rdyx;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] addr;
        logic              rdya;
    } ent_t;

    ent_t q[$];
    logic exp_valid, exp_mode, exp_full;
    logic [P_W-1:0] exp_px;
    logic [ADDR_W-1:0] exp_addr;
    logic [TAG_W-1:0] exp_tag;

    int n_chk = 0;
    int n_pass = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic wake(input logic [P_W-1:0] p);
        return (va && pa == p) || (vm && pm == p) || (vl && !mode_ls && pl == p);
    endfunction

    function automatic logic tag_live(input logic [TAG_W-1:0] t);
        foreach (q[i]) if (q[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_valid = 0; exp_mode = 0; exp_px = 0; exp_addr = 0; exp_tag = 0; exp_full = 0;
    endtask

    // Queue-level view: issue from the front, capture/wakeup over live entries, append at back.
    task automatic model_update();
        int old_size;
        logic issue;
        ent_t e;
        if (flush) begin
            model_reset();
            return;
        end
        issue = 0;
        if (!freeze) begin
            if (q.size() > 0 && q[0].rdya && q[0].rdyx && !(q[0].mode && full_fifo)) begin
                issue = 1;
                exp_mode = q[0].mode; exp_px = q[0].px; exp_addr = q[0].addr; exp_tag = q[0].tag;
            end
            exp_valid = issue;
        end
        old_size = q.size();
        foreach (q[i]) begin
            if (!q[i].rdya && agu_v && q[i].tag == agu_tag) begin
                q[i].rdya = 1; q[i].addr = agu_addr;
            end
            if (q[i].mode && wake(q[i].px)) q[i].rdyx = 1;
        end
        if (issue) void'(q.pop_front());
        if (alloc_valid && old_size < DEPTH) begin
            e.mode = alloc_mode; e.px = alloc_px; e.tag = alloc_tag;
            e.rdyx = !alloc_mode || alloc_rdy || wake(alloc_px);
            e.rdya = agu_v && agu_tag == alloc_tag;
            e.addr = e.rdya ? agu_addr : '0;
            q.push_back(e);
        end
        exp_full = (q.size() == DEPTH);
    endtask

    task automatic clear_pulses();
        flush = 0; alloc_valid = 0; alloc_mode = 0; alloc_px = 0; alloc_rdy = 0; alloc_tag = 0;
        agu_v = 0; agu_tag = 0; agu_addr = 0; va = 0; vm = 0; vl = 0; pa = 0; pm = 0; pl = 0;
        mode_ls = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        clear_pulses();
    endtask

    task automatic set_alloc(input logic m, input int px, input logic rdy, input int tag);
        alloc_valid = 1; alloc_mode = m; alloc_px = P_W'(px); alloc_rdy = rdy; alloc_tag = TAG_W'(tag);
    endtask

    task automatic set_agu(input int tag, input int addr);
        agu_v = 1; agu_tag = TAG_W'(tag); agu_addr = ADDR_W'(addr);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid_ls", 32'(valid_ls), 32'(exp_valid));
            chk("full_LSQ", 32'(full_lsq), 32'(exp_full));
            if (exp_valid) begin
                chk("mode", 32'(mode_o), 32'(exp_mode));
                chk("Px", 32'(px_o), 32'(exp_px));
                chk("Addr", 32'(addr_o), 32'(exp_addr));
                chk("tag_ROB_ls", 32'(tag_o), 32'(exp_tag));
            end
        end
    end

    initial begin
        int t;
        rst_n = 0; freeze = 0; full_fifo = 0;
        clear_pulses();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid_ls", 32'(valid_ls), 0);
        chk("reset full_LSQ", 32'(full_lsq), 0);
        chk("reset Addr", 32'(addr_o), 0);
        rst_n = 1;
        cmp_en = 1;

        // Load tag3 Px7, address arrives the next cycle, issues one edge later.
        set_alloc(0, 7, 0, 3); cyc();
        set_agu(3, 16'h0040); cyc();
        chk("t1 no early issue", 32'(valid_ls), 0);
        cyc();
        chk("t1 valid", 32'(valid_ls), 1);
        chk("t1 mode", 32'(mode_o), 0);
        chk("t1 Px", 32'(px_o), 7);
        chk("t1 Addr", 32'(addr_o), 32'h40);
        chk("t1 tag", 32'(tag_o), 3);
        chk("t1 full", 32'(full_lsq), 0);

        // Store waits on its data register until the mul wakeup.
        set_alloc(1, 9, 0, 5); set_agu(5, 16'h0010); cyc();
        cyc();
        chk("t2 wait data", 32'(valid_ls), 0);
        vm = 1; pm = 9; cyc();
        chk("t2 still waiting", 32'(valid_ls), 0);
        cyc();
        chk("t2 valid", 32'(valid_ls), 1);
        chk("t2 mode", 32'(mode_o), 1);
        chk("t2 Addr", 32'(addr_o), 32'h10);

        // Fill, drop the 9th, head blocks in-order issue.
        for (int i = 0; i < 8; i++) begin set_alloc(0, i, 0, i); cyc(); end
        chk("t3 full", 32'(full_lsq), 1);
        set_alloc(0, 8, 0, 8); cyc();
        chk("t3 full after drop", 32'(full_lsq), 1);
        for (int i = 1; i < 8; i++) begin set_agu(i, 16'h100 + i); cyc(); end
        chk("t3 head blocks", 32'(valid_ls), 0);
        set_agu(0, 16'h100); cyc();
        chk("t3 head latched only", 32'(valid_ls), 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t3 order valid", 32'(valid_ls), 1);
            chk("t3 order tag", 32'(tag_o), 32'(i));
            if (i == 0) chk("t3 full drops", 32'(full_lsq), 0);
        end
        set_agu(8, 16'h1234); cyc();
        cyc();
        chk("t3 dropped never issues", 32'(valid_ls), 0);

        // Freeze holds the issued op.
        set_alloc(0, 1, 0, 10); set_agu(10, 16'h0A0); cyc();
        set_alloc(0, 2, 0, 11); set_agu(11, 16'h0B0); cyc();
        chk("t4 tag10", 32'(tag_o), 10);
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4 hold valid", 32'(valid_ls), 1);
            chk("t4 hold tag", 32'(tag_o), 10);
        end
        freeze = 0; cyc();
        chk("t4 release tag", 32'(tag_o), 11);
        chk("t4 release Addr", 32'(addr_o), 32'hB0);

        // Flush beats same-cycle alloc and AGU.
        for (int i = 12; i < 16; i++) begin set_alloc(0, i, 0, i); cyc(); end
        flush = 1; set_alloc(0, 3, 0, 16); set_agu(12, 16'h0C0); cyc();
        chk("t5 valid", 32'(valid_ls), 0);
        chk("t5 full", 32'(full_lsq), 0);
        set_agu(13, 16'h0D0); cyc();
        cyc();
        chk("t5 empty", 32'(valid_ls), 0);

        // Store blocked by full store buffer, then tail wrap.
        set_alloc(1, 3, 1, 20); set_agu(20, 16'h0200); cyc();
        full_fifo = 1; cyc(); cyc();
        chk("t6 fifo blocks", 32'(valid_ls), 0);
        full_fifo = 0; cyc();
        chk("t6 store issues", 32'(valid_ls), 1);
        chk("t6 store tag", 32'(tag_o), 20);
        for (int i = 0; i < DEPTH + 3; i++) begin
            set_alloc(0, i, 0, 21 + i); set_agu(21 + i, 16'h300 + i); cyc();
            if (i > 0) chk("t6 wrap tag", 32'(tag_o), 32'(20 + i));
        end
        cyc();
        chk("t6 last tag", 32'(tag_o), 31);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            flush     = ($urandom_range(0, 99) == 0);
            freeze    = ($urandom_range(0, 5) == 0);
            full_fifo = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0) begin
                do t = $urandom_range(0, 31); while (tag_live(TAG_W'(t)));
                set_alloc(1'($urandom_range(0, 1)), $urandom_range(0, 7),
                          ($urandom_range(0, 3) == 0), t);
            end
            if ($urandom_range(0, 1) != 0) begin
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    set_agu(q[$urandom_range(0, q.size() - 1)].tag, $urandom_range(0, 65535));
                else if (alloc_valid && $urandom_range(0, 1) != 0)
                    set_agu(alloc_tag, $urandom_range(0, 65535));
                else
                    set_agu($urandom_range(0, 31), $urandom_range(0, 65535));
            end
            va = ($urandom_range(0, 3) == 0); pa = P_W'($urandom_range(0, 7));
            vm = ($urandom_range(0, 3) == 0); pm = P_W'($urandom_range(0, 7));
            vl = ($urandom_range(0, 3) == 0); pl = P_W'($urandom_range(0, 7));
            mode_ls = 1'($urandom_range(0, 1));
            cyc();
        end
        freeze = 0; full_fifo = 0;
        repeat (2) @(negedge clk);
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
